// File: rtl/dm_responder.sv
// Data-memory responder: word/half/byte stores, sign-extending byte load capture, zero-fill sweep after reset.
// Load data is registered with 1-edge latency; busy is high during the sweep, and all accesses are dropped while it is high.
module dm_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        sb_flag,
    input  logic        sh_flag,
    input  logic        lb_flag,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        align_err,
    output logic [15:0] st_cnt
);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t        state;
    logic [AW-1:0] init_cnt;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [7:0]    cur_byte;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          mis;
    logic          commit;
    logic          unused_addr;

    assign idx         = addr[AW+1:2];
    assign lane        = addr[1:0];
    assign cur_word    = mem[idx];
    assign cur_byte    = cur_word[{lane, 3'b000} +: 8];
    assign unused_addr = ^addr[31:AW+2];

    // Byte enables and lane-replicated write data; priority sb > sh > word.
    always_comb begin
        be  = 4'b1111;
        wd  = wdata;
        mis = 1'b0;
        if (sb_flag) begin
            wd = {4{wdata[7:0]}};
            case (lane)
                2'd0:    be = 4'b0001;
                2'd1:    be = 4'b0010;
                2'd2:    be = 4'b0100;
                default: be = 4'b1000;
            endcase
        end else if (sh_flag) begin
            wd  = {2{wdata[15:0]}};
            be  = addr[1] ? 4'b1100 : 4'b0011;
            mis = addr[0];
        end else begin
            mis = (lane != 2'd0);
        end
    end

    assign commit = (state == S_READY) && memwrite && !mis;

    // The array has no reset; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= '0;
        end else if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wd[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            busy      <= 1'b1;
            rdata     <= '0;
            align_err <= 1'b0;
            st_cnt    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + AW'(1);
                    if (init_cnt == AW'(DEPTH - 1)) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (memwrite) begin
                        if (mis) align_err <= 1'b1;
                        else     st_cnt    <= st_cnt + 16'd1;
                    end else if (lb_flag) begin
                        rdata <= {{24{cur_byte[7]}}, cur_byte};
                    end else begin
                        rdata <= cur_word;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder (DEPTH=16): behavioural memory model checked every cycle plus directed literal checks.
module tb_dm_responder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite, sb_flag, sh_flag, lb_flag;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy, align_err;
    logic [15:0] st_cnt;

    int checks   = 0;
    int failures = 0;

    dm_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .sb_flag(sb_flag),
        .sh_flag(sh_flag), .lb_flag(lb_flag), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .align_err(align_err), .st_cnt(st_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory as an array of words, sweep as an edge count since reset.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [15:0] m_cnt;
    int          m_edges;

    always @(posedge clk) begin
        logic [31:0] w;
        logic [7:0]  b;
        int          i;
        bit          ok;
        i = int'(addr[5:2]);
        if (reset) begin
            m_rdata = 0; m_err = 0; m_cnt = 0; m_edges = 0;
        end else if (m_edges < DEPTH) begin
            m_edges++;
            if (m_edges == DEPTH) foreach (m_mem[j]) m_mem[j] = 0;
        end else if (memwrite) begin
            w = m_mem[i];
            if (sb_flag) begin
                ok = 1;
                w[8*addr[1:0] +: 8] = wdata[7:0];
            end else if (sh_flag) begin
                ok = (addr[0] == 1'b0);
                w[16*addr[1] +: 16] = wdata[15:0];
            end else begin
                ok = (addr[1:0] == 2'b00);
                w = wdata;
            end
            if (ok) begin
                m_mem[i] = w;
                m_cnt++;
            end else begin
                m_err = 1;
            end
        end else begin
            b = m_mem[i][8*addr[1:0] +: 8];
            m_rdata = lb_flag ? {{24{b[7]}}, b} : m_mem[i];
        end
        #1;
        chk("model_rdata", rdata, m_rdata);
        chk("model_busy", {31'b0, busy}, {31'b0, m_edges < DEPTH});
        chk("model_align_err", {31'b0, align_err}, {31'b0, m_err});
        chk("model_st_cnt", {16'b0, st_cnt}, {16'b0, m_cnt});
    end

    // Drive one cycle of inputs; returns at the following negedge.
    task automatic op(input logic mw, input logic sb, input logic sh, input logic lb,
                      input logic [31:0] a, input logic [31:0] wd);
        memwrite = mw; sb_flag = sb; sh_flag = sh; lb_flag = lb; addr = a; wdata = wd;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        memwrite = 0; sb_flag = 0; sh_flag = 0; lb_flag = 0; addr = 0; wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_align_err", {31'b0, align_err}, 32'h0);
        chk("rst_st_cnt", {16'b0, st_cnt}, 32'h0);

        // Sweep with a store held on word 0 throughout; it must be ignored.
        reset = 1'b0;
        repeat (15) op(1, 0, 0, 0, 32'h0, 32'hDEADBEEF);
        chk("busy_edge15", {31'b0, busy}, 32'h1);
        op(1, 0, 0, 0, 32'h0, 32'hDEADBEEF);
        chk("busy_edge16", {31'b0, busy}, 32'h0);
        chk("init_store_cnt", {16'b0, st_cnt}, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            op(0, 0, 0, 0, 32'(i * 4), 32'h0);
            chk("sweep_zero", rdata, 32'h0);
        end

        op(1, 0, 0, 0, 32'h8, 32'h11223344);
        op(1, 1, 0, 0, 32'h9, 32'h000000AA);
        op(0, 0, 0, 0, 32'h8, 32'h0);
        chk("sb_merge", rdata, 32'h1122AA44);
        chk("st_cnt_2", {16'b0, st_cnt}, 32'h2);

        op(1, 0, 0, 0, 32'h8, 32'h11223344);
        op(1, 0, 1, 0, 32'hA, 32'h0000BEEF);
        op(0, 0, 0, 0, 32'h8, 32'h0);
        chk("sh_upper", rdata, 32'hBEEF3344);
        op(0, 0, 0, 1, 32'hB, 32'h0);
        chk("lb_neg", rdata, 32'hFFFFFFBE);
        op(0, 0, 0, 1, 32'h8, 32'h0);
        chk("lb_pos", rdata, 32'h00000044);

        op(1, 0, 0, 0, 32'h4, 32'h55667788);
        op(1, 0, 0, 0, 32'h6, 32'h99999999);
        chk("sw_mis_err", {31'b0, align_err}, 32'h1);
        chk("sw_mis_cnt", {16'b0, st_cnt}, 32'h5);
        op(0, 1, 1, 0, 32'h4, 32'h0);
        chk("sw_mis_nowrite", rdata, 32'h55667788);
        op(1, 0, 1, 0, 32'h3, 32'h00001234);
        op(0, 0, 0, 0, 32'h0, 32'h0);
        chk("sh_mis_nowrite", rdata, 32'h0);
        chk("sh_mis_cnt", {16'b0, st_cnt}, 32'h5);
        chk("err_sticky", {31'b0, align_err}, 32'h1);
        op(0, 0, 0, 0, 32'h4, 32'h0);
        op(1, 1, 0, 1, 32'hC, 32'h00000080);
        chk("store_holds_rdata", rdata, 32'h55667788);
        op(0, 0, 0, 1, 32'hC, 32'h0);
        chk("lb_lane0_neg", rdata, 32'hFFFFFF80);

        // Reset, then reset again 5 edges into the sweep.
        reset = 1'b1;
        op(0, 0, 0, 0, 32'h0, 32'h0);
        chk("rst2_align_err", {31'b0, align_err}, 32'h0);
        chk("rst2_st_cnt", {16'b0, st_cnt}, 32'h0);
        reset = 1'b0;
        repeat (5) op(0, 0, 0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        op(0, 0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        repeat (15) op(0, 0, 0, 0, 32'h0, 32'h0);
        chk("restart_busy15", {31'b0, busy}, 32'h1);
        op(0, 0, 0, 0, 32'h0, 32'h0);
        chk("restart_busy16", {31'b0, busy}, 32'h0);
        op(0, 0, 0, 0, 32'hC, 32'h0);
        chk("restart_cleared", rdata, 32'h0);

        op(1, 0, 0, 0, 32'h40, 32'h5);
        op(0, 0, 0, 0, 32'h3, 32'h0);
        chk("wrap_index", rdata, 32'h5);
        for (int i = 0; i < 65534; i++) op(1, 1, 0, 0, 32'h10, 32'(i));
        chk("cnt_ffff", {16'b0, st_cnt}, 32'h0000FFFF);
        op(1, 1, 0, 0, 32'h10, 32'h0);
        chk("cnt_wrap", {16'b0, st_cnt}, 32'h0);
        op(0, 0, 0, 0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
